// File: rtl/dec_scan.sv
// dec_scan: registered one-hot decoder with a scan sequencer.
//
// Direct mode latches a select code and holds the matching one-hot output.
// Scan mode walks a single high bit from the start index upwards, dwelling
// DWELL cycles on each output. The walk either ends after the top output
// (single pass) or wraps around until stopped (continuous).
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  command strobe, accepted when in_valid && in_ready
//   in_ready  high when not scanning and stop is low (combinational)
//   sel       start/select index, sampled on acceptance
//   mode      00 direct, 01 scan single-pass, 10 scan continuous, 11 direct
//   stop      abort, highest priority
//   D         registered one-hot (or all-zero) output
//   busy      registered, high while scanning
//   done      registered one-cycle pulse at the end of a single-pass scan
module dec_scan #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      sel,
  input  logic [1:0]        mode,
  input  logic              stop,
  output logic [(1<<N)-1:0] D,
  output logic              busy,
  output logic              done
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);
  localparam logic [N-1:0]  IdxMax    = {N{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StScan
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_idx;
  logic [DW-1:0] r_dwell;
  logic          r_cont;
  logic [W-1:0]  r_d;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_is_scan_cmd;
  logic [W-1:0]  w_onehot;

  assign in_ready      = (r_state != StScan) && !stop;
  assign w_accept      = in_valid && in_ready;
  // mode 11 falls through to direct behaviour
  assign w_is_scan_cmd = (mode == 2'b01) || (mode == 2'b10);
  assign w_onehot      = {{(W-1){1'b0}}, 1'b1} << sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_dwell <= '0;
      r_cont  <= 1'b0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a command on the same edge.
        r_state <= StIdle;
        r_dwell <= '0;
        r_d     <= '0;
        r_busy  <= 1'b0;
      end else if (w_accept) begin
        r_idx   <= sel;
        r_d     <= w_onehot;
        r_dwell <= '0;
        if (w_is_scan_cmd) begin
          r_state <= StScan;
          r_busy  <= 1'b1;
          r_cont  <= (mode == 2'b10);
        end else begin
          r_state <= StHold;
          r_busy  <= 1'b0;
        end
      end else if (r_state == StScan) begin
        if (r_dwell == DwellLast) begin
          r_dwell <= '0;
          if (r_idx != IdxMax) begin
            r_idx <= r_idx + 1'b1;
            r_d   <= r_d << 1;
          end else if (r_cont) begin
            r_idx <= '0;
            r_d   <= {{(W-1){1'b0}}, 1'b1};
          end else begin
            // Single pass never wraps: finish after the top output.
            r_state <= StIdle;
            r_d     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end else begin
          r_dwell <= r_dwell + 1'b1;
        end
      end
    end
  end

  assign D    = r_d;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_dec_scan.sv
module tb_dec_scan;

  localparam int unsigned N     = 3;
  localparam int unsigned DWELL = 2;
  localparam int unsigned NOUT  = 1 << N;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     sel = '0;
  logic [1:0]       mode = 2'b00;
  logic             stop = 1'b0;
  logic [NOUT-1:0]  D;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  dec_scan #(.N(N), .DWELL(DWELL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .stop     (stop),
    .D        (D),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 hold, 2 scan. Scan position is derived from elapsed
  // cycles since the start, not from a stepped index.
  int m_kind  = 0;
  int m_start = 0;
  int m_t     = 0;
  bit m_cont  = 0;
  bit m_done  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind  <= 0;
      m_start <= 0;
      m_t     <= 0;
      m_cont  <= 0;
      m_done  <= 0;
    end else begin
      m_done <= 0;
      if (stop) begin
        m_kind <= 0;
      end else if (in_valid && m_kind != 2) begin
        m_start <= int'(sel);
        m_t     <= 0;
        if (mode == 2'b01 || mode == 2'b10) begin
          m_kind <= 2;
          m_cont <= (mode == 2'b10);
        end else begin
          m_kind <= 1;
        end
      end else if (m_kind == 2) begin
        m_t <= m_t + 1;
        if (!m_cont && (m_t + 1) == (int'(NOUT) - m_start) * int'(DWELL)) begin
          m_kind <= 0;
          m_done <= 1;
        end
      end
    end
  end

  function automatic logic [NOUT-1:0] model_d();
    logic [NOUT-1:0] one;
    int pos;
    one = 1;
    if (m_kind == 1) return one << m_start;
    if (m_kind == 2) begin
      pos = (m_start + m_t / int'(DWELL)) % int'(NOUT);
      return one << pos;
    end
    return '0;
  endfunction

  always @(negedge clk) begin
    check("model_D", 32'(D), 32'(model_d()));
    check("model_busy", 32'(busy), 32'(m_kind == 2));
    check("model_done", 32'(done), 32'(m_done));
    check("model_ready", 32'(in_ready), 32'((m_kind != 2) && !stop));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [N-1:0] s, input logic [1:0] m);
    in_valid = 1'b1;
    sel      = s;
    mode     = m;
    step(1);
    in_valid = 1'b0;
    sel      = '0;
    mode     = 2'b00;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_D", 32'(D), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    #10 rst_n = 1'b1;
    step(1);

    // Direct select and replacement without a zero cycle.
    cmd(3'd5, 2'b00);
    check("dir5_D", 32'(D), 32'h20);
    step(1);
    check("dir5_hold", 32'(D), 32'h20);
    cmd(3'd0, 2'b00);
    check("dir0_D", 32'(D), 32'h01);

    // Single-pass scan from 6.
    cmd(3'd6, 2'b01);
    check("sp_D0", 32'(D), 32'h40);
    check("sp_busy0", 32'(busy), 32'h1);
    check("sp_ready0", 32'(in_ready), 32'h0);
    step(1); check("sp_D1", 32'(D), 32'h40);
    step(1); check("sp_D2", 32'(D), 32'h80);
    step(1); check("sp_D3", 32'(D), 32'h80);
    check("sp_busy3", 32'(busy), 32'h1);
    step(1);
    check("sp_D4", 32'(D), 32'h0);
    check("sp_done4", 32'(done), 32'h1);
    check("sp_busy4", 32'(busy), 32'h0);
    step(1); check("sp_done5", 32'(done), 32'h0);

    // Continuous scan from 7 with wrap; a command during scan is ignored.
    cmd(3'd7, 2'b10);
    check("cs_D0", 32'(D), 32'h80);
    step(1); check("cs_D1", 32'(D), 32'h80);
    step(1); check("cs_D2", 32'(D), 32'h01);
    step(1); check("cs_D3", 32'(D), 32'h01);
    step(1); check("cs_D4", 32'(D), 32'h02);
    in_valid = 1'b1; sel = 3'd3; mode = 2'b00;
    step(1); check("cs_ign_D5", 32'(D), 32'h02);
    step(1); check("cs_ign_D6", 32'(D), 32'h04);
    in_valid = 1'b0; sel = '0;
    stop = 1'b1;
    step(1);
    check("cs_stop_D", 32'(D), 32'h0);
    check("cs_stop_busy", 32'(busy), 32'h0);
    check("cs_stop_done", 32'(done), 32'h0);
    stop = 1'b0;
    step(1);

    // Stop and command together in HOLD: command dropped.
    cmd(3'd1, 2'b00);
    check("h1_D", 32'(D), 32'h02);
    stop = 1'b1; in_valid = 1'b1; sel = 3'd4; mode = 2'b00;
    #1 check("stop_ready", 32'(in_ready), 32'h0);
    step(1);
    check("hs_D", 32'(D), 32'h0);
    stop = 1'b0; in_valid = 1'b0; sel = '0;
    step(1); check("hs_D_idle", 32'(D), 32'h0);

    // Async reset mid-scan.
    cmd(3'd0, 2'b01);
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_D", 32'(D), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_done", 32'(done), 32'h0);
    #3 rst_n = 1'b1;
    #1 check("ar_ready", 32'(in_ready), 32'h1);
    cmd(3'd2, 2'b00);
    check("ar_dir2", 32'(D), 32'h04);

    // mode 11 acts as direct.
    cmd(3'd4, 2'b11);
    check("m11_D", 32'(D), 32'h10);
    check("m11_busy", 32'(busy), 32'h0);
    step(2); check("m11_hold", 32'(D), 32'h10);

    // Full single pass from 0, checked by the model only.
    cmd(3'd0, 2'b01);
    step(int'(NOUT * DWELL) + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
